ea_unit: RTL
============

// Module: ea_unit
// PURPOSE
//  Parametrised operand effective-address engine for the VM1-family core. Runs all eight
//  PDP-11 addressing modes as one hardware sequence rather than as microcode steps.
//  Given mode/register/byte flag, it reads the register file, performs index and deferred
//  bus reads, and returns the EA plus a single deferred register writeback.
//  Sits between the control unit (start/done), the register file and the bus interface.
// PARAMETERS
//  DW      16  data/address width, >=8
//  NREG    8   number of general registers, power of 2, >=8
//  RW      3   register index width, must equal log2(NREG)
//  SP_IDX  6   stack pointer index (byte autoinc/dec steps by 2 for SP and PC)
//  PC_IDX  7   program counter index (index word fetched from, and PC advanced)
// PORTS
//  clk          in   1   clock
//  reset_n      in   1   synchronous active-low reset
//  ce           in   1   clock enable; no state, output or bus change when 0
//  start        in   1   begin EA sequence; sampled in IDLE with ce=1
//  mode         in   3   addressing mode 0..7
//  regno        in   RW  register number
//  byte_op      in   1   byte operand
//  busy         out  1   sequence in progress (start ignored)
//  done         out  1   one ce-cycle pulse: result valid
//  err          out  1   with done: odd address or bus error
//  reg_mode     out  1   with done: mode 0, operand is register regno, ea=0
//  ea           out  DW  effective address, held until next start
//  reg_rd_idx   out  RW  register file read index
//  reg_rd_data  in   DW  register file read data, combinational from reg_rd_idx
//  reg_wr_en    out  1   writeback strobe, coincident with done
//  reg_wr_idx   out  RW  writeback index
//  reg_wr_data  out  DW  writeback value
//  bus_req      out  1   read request, held until bus_ack/bus_err
//  bus_addr     out  DW  read address, stable while bus_req
//  bus_ack      in   1   read complete, bus_din valid
//  bus_din      in   DW  read data
//  bus_err      in   1   bus timeout/error terminating the request
// BEHAVIOUR
//  Reset: state IDLE; busy, done, err, reg_mode, reg_wr_en and bus_req are 0; ea=0.
//  FSM: IDLE -> CALC -> [IDX_RD -> IDX_ADD] -> [IND_RD] -> FIN -> IDLE.
//  Latched copies of mode, regno and byte_op are taken at start.
//   IDX_RD is visited for modes 6/7; IND_RD for modes 3/5/7. All transitions are ce-gated.
//  CALC drives reg_rd_idx=regno. Step = 1 if byte_op and regno not SP_IDX/PC_IDX; else 2.
//  Modes 3/5/7 always use step 2.
//   m0 reg_mode=1 | m1 ea=R | m2 ea=R, wb R+step | m3 ea=mem[R], wb R+2
//   m4 ea=R-step, wb same | m5 ea=mem[R-2], wb R-2
//   m6 ea=X+R', wb PC+2 | m7 ea=mem[X+R'], wb PC+2
//   X=mem[PC], read in IDX_RD. R' = PC+2 when regno==PC_IDX, else R.
//  Register value is sampled once in CALC. R' for regno==PC_IDX is the CALC-sampled
//   PC plus 2, not a re-read.
//  Latency in ce-cycles from start: m0,m1,m2,m4 done at +2; m3,m5 done at +3+W.
//   m6 done at +4+W; m7 done at +5+2W. W = bus wait cycles before ack (>=0).
//  Bus: bus_req rises on entry to a read state and stays high with a stable address until
//   bus_ack or bus_err. bus_din is captured on ack, and bus_req drops the same cycle.
//  Writeback is deferred: reg_wr_en pulses only with done and only if err=0.
//   At most one register is written per sequence.
//  Odd address: a bus read to an odd address, or a word-op final EA that is odd, gives
//   err=1 and done; no bus request is issued and there is no writeback.
//  bus_err: the sequence aborts, with err=1 and done next ce-cycle; no writeback; ea=0.
//  Arithmetic is modulo 2^DW with no carry/flag side effects.
//  start while busy is ignored. start on the same cycle as done is ignored; accepted from
//   the next cycle.
//  Reset mid-sequence returns to IDLE in one cycle: bus_req drops, no writeback, no done.
//  ce=0 in any state freezes all outputs, including a held bus_req.
// TESTING
//  T1 m2 R3=16'h1000 byte: ea=1000, wr R3=1001 at +2. Same with regno=SP_IDX: wr 1002.
//  T2 m4 R0=0 word: ea=FFFE, wr R0=FFFE (wrap). m0 R5: reg_mode=1, no wr, no bus_req.
//  T3 m6 regno=PC_IDX, PC=0200, mem[0200]=0010, W=2: bus_addr=0200 held 3 cycles;
//   ea=0212, wr PC=0202, done at +6.
//  T4 m7 R1=0100, PC=0300, mem[0300]=0004, mem[0104]=2000: ea=2000, wr PC=0302.
//  T5 m5 R2=0400 with bus_err on read: err=1, done, no reg_wr_en. m1 R2=0401 word: err.
//  T6 reset_n low while m3 waits on ack: bus_req=0 next cycle, no done/wr. ce toggled
//   50%: results identical to T3 with latencies scaled.

Source files
------------

// File: rtl/ea_unit.sv
`default_nettype none
// ============================================================================
// Module      : ea_unit
// Description : Operand effective-address engine for the VM1-family core.
//               Runs any of the eight PDP-11 addressing modes as one
//               hardware sequence. It reads the register file, issues the
//               index and deferred bus reads, and returns the EA together
//               with at most one deferred register writeback.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset_n       clock, synchronous active-low reset
//   ce                 clock enable; everything freezes while low
//   start/mode/regno/byte_op   request from the control unit
//   busy/done/err/reg_mode/ea  status and result back to the control unit
//   reg_rd_idx/reg_rd_data     register file read port (combinational)
//   reg_wr_en/idx/data         deferred writeback, strobed with done
//   bus_req/addr/ack/din/err   read-only bus master port
// ============================================================================
module ea_unit #(
    parameter int DW     = 16,
    parameter int NREG   = 8,
    parameter int RW     = 3,
    parameter int SP_IDX = 6,
    parameter int PC_IDX = 7
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic [RW-1:0] regno,
    input  logic          byte_op,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          reg_mode,
    output logic [DW-1:0] ea,
    output logic [RW-1:0] reg_rd_idx,
    input  logic [DW-1:0] reg_rd_data,
    output logic          reg_wr_en,
    output logic [RW-1:0] reg_wr_idx,
    output logic [DW-1:0] reg_wr_data,
    output logic          bus_req,
    output logic [DW-1:0] bus_addr,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_din,
    input  logic          bus_err
);

    localparam logic [RW-1:0] c_sp_idx = RW'(SP_IDX % NREG);
    localparam logic [RW-1:0] c_pc_idx = RW'(PC_IDX % NREG);
    localparam logic [DW-1:0] c_one    = DW'(1);
    localparam logic [DW-1:0] c_two    = DW'(2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CALC    = 3'd1,
        S_IDX_RD  = 3'd2,
        S_IDX_ADD = 3'd3,
        S_IND_RD  = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;

    // Request latched at start
    logic [2:0]    r_mode;
    logic [RW-1:0] r_regno;
    logic          r_byte;
    // PC sampled in IDLE (read port points at PC while idle)
    logic [DW-1:0] r_pc;
    // R' for the index add, and the fetched index word X
    logic [DW-1:0] r_rp;
    logic [DW-1:0] r_x;
    logic [DW-1:0] r_ea;
    logic [DW-1:0] r_bus_addr;
    logic          r_err;
    logic          r_wb_pend;
    logic [RW-1:0] r_wb_idx;
    logic [DW-1:0] r_wb_data;

    logic          w_is_sppc;
    logic [DW-1:0] w_step;
    logic [DW-1:0] w_r;
    logic [DW-1:0] w_pc_now;
    logic [DW-1:0] w_r_dec;
    logic [DW-1:0] w_r_dec2;
    logic [DW-1:0] w_sum;
    logic [DW-1:0] w_calc_addr;
    logic          w_calc_bus;
    logic          w_word;

    // ------------------------------------------------------------------
    // Shared arithmetic
    // ------------------------------------------------------------------
    assign w_is_sppc = (r_regno == c_sp_idx) || (r_regno == c_pc_idx);
    // Byte autoinc/dec steps by 1 except on SP and PC, which stay word aligned
    assign w_step    = (r_byte && !w_is_sppc) ? c_one : c_two;
    assign w_r       = reg_rd_data;
    // When the operand register is PC itself, the CALC-cycle read is the PC
    assign w_pc_now  = (r_regno == c_pc_idx) ? reg_rd_data : r_pc;
    assign w_r_dec   = w_r - w_step;
    assign w_r_dec2  = w_r - c_two;
    assign w_sum     = r_x + r_rp;
    assign w_word    = !r_byte;

    // First bus address of the sequence and whether one is needed at all
    always_comb begin
        w_calc_addr = w_r;
        w_calc_bus  = 1'b0;
        case (r_mode)
            3'd3: begin
                w_calc_addr = w_r;
                w_calc_bus  = 1'b1;
            end
            3'd5: begin
                w_calc_addr = w_r_dec2;
                w_calc_bus  = 1'b1;
            end
            3'd6, 3'd7: begin
                w_calc_addr = w_pc_now;
                w_calc_bus  = 1'b1;
            end
            default: begin
                w_calc_addr = w_r;
                w_calc_bus  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else if (ce) begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        reg_mode    = 1'b0;
        reg_wr_en   = 1'b0;
        bus_req     = 1'b0;
        reg_rd_idx  = r_regno;

        case (r_state)
            S_IDLE: begin
                reg_rd_idx = c_pc_idx;
                if (start) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                // An odd first read address ends the sequence without a request
                if (w_calc_bus && !w_calc_addr[0]) begin
                    w_next = r_mode[2] && r_mode[1] ? S_IDX_RD : S_IND_RD;
                end else begin
                    w_next = S_FIN;
                end
            end
            S_IDX_RD: begin
                busy    = 1'b1;
                bus_req = 1'b1;
                if (bus_err) begin
                    w_next = S_FIN;
                end else if (bus_ack) begin
                    w_next = S_IDX_ADD;
                end
            end
            S_IDX_ADD: begin
                busy = 1'b1;
                if ((r_mode == 3'd7) && !w_sum[0]) begin
                    w_next = S_IND_RD;
                end else begin
                    w_next = S_FIN;
                end
            end
            S_IND_RD: begin
                busy    = 1'b1;
                bus_req = 1'b1;
                if (bus_err || bus_ack) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                err       = r_err;
                reg_mode  = (r_mode == 3'd0);
                reg_wr_en = r_wb_pend && !r_err;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign ea          = r_ea;
    assign bus_addr    = r_bus_addr;
    assign reg_wr_idx  = r_wb_idx;
    assign reg_wr_data = r_wb_data;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mode     <= 3'd0;
            r_regno    <= '0;
            r_byte     <= 1'b0;
            r_pc       <= '0;
            r_rp       <= '0;
            r_x        <= '0;
            r_ea       <= '0;
            r_bus_addr <= '0;
            r_err      <= 1'b0;
            r_wb_pend  <= 1'b0;
            r_wb_idx   <= '0;
            r_wb_data  <= '0;
        end else if (ce) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode    <= mode;
                        r_regno   <= regno;
                        r_byte    <= byte_op;
                        r_pc      <= reg_rd_data;
                        r_err     <= 1'b0;
                        r_wb_pend <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_err      <= 1'b0;
                    r_wb_pend  <= 1'b0;
                    r_wb_idx   <= r_regno;
                    r_bus_addr <= w_calc_addr;
                    case (r_mode)
                        3'd0: begin
                            r_ea <= '0;
                        end
                        3'd1: begin
                            r_err <= w_word && w_r[0];
                            r_ea  <= (w_word && w_r[0]) ? '0 : w_r;
                        end
                        3'd2: begin
                            r_err     <= w_word && w_r[0];
                            r_ea      <= (w_word && w_r[0]) ? '0 : w_r;
                            r_wb_pend <= 1'b1;
                            r_wb_data <= w_r + w_step;
                        end
                        3'd4: begin
                            r_err     <= w_word && w_r_dec[0];
                            r_ea      <= (w_word && w_r_dec[0]) ? '0 : w_r_dec;
                            r_wb_pend <= 1'b1;
                            r_wb_data <= w_r_dec;
                        end
                        3'd3: begin
                            r_wb_pend <= 1'b1;
                            r_wb_data <= w_r + c_two;
                        end
                        3'd5: begin
                            r_wb_pend <= 1'b1;
                            r_wb_data <= w_r_dec2;
                        end
                        default: begin
                            // Modes 6/7: PC always advances past the index word
                            r_rp      <= (r_regno == c_pc_idx) ? w_r + c_two : w_r;
                            r_wb_pend <= 1'b1;
                            r_wb_idx  <= c_pc_idx;
                            r_wb_data <= w_pc_now + c_two;
                        end
                    endcase
                    if (w_calc_bus && w_calc_addr[0]) begin
                        r_err <= 1'b1;
                        r_ea  <= '0;
                    end
                end
                S_IDX_RD: begin
                    if (bus_err) begin
                        r_err <= 1'b1;
                        r_ea  <= '0;
                    end else if (bus_ack) begin
                        r_x <= bus_din;
                    end
                end
                S_IDX_ADD: begin
                    if (r_mode == 3'd7) begin
                        r_bus_addr <= w_sum;
                        if (w_sum[0]) begin
                            r_err <= 1'b1;
                            r_ea  <= '0;
                        end
                    end else if (w_word && w_sum[0]) begin
                        r_err <= 1'b1;
                        r_ea  <= '0;
                    end else begin
                        r_ea <= w_sum;
                    end
                end
                S_IND_RD: begin
                    if (bus_err) begin
                        r_err <= 1'b1;
                        r_ea  <= '0;
                    end else if (bus_ack) begin
                        if (w_word && bus_din[0]) begin
                            r_err <= 1'b1;
                            r_ea  <= '0;
                        end else begin
                            r_ea <= bus_din;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
